// File: rtl/tsxb_audio_pkg.sv
// Shared audio definitions for the sound generator and the I2S DAC serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tsxb_audio_pkg;

    // Native sample width produced by the sound block.
    localparam int SAMPLE_W    = 16;
    // I2S frame: 64 bit slots, each slot lasting 4 MCLK periods (MCLK = 256*fs).
    localparam int FRAME_SLOTS = 64;
    localparam int SLOT_MCLK   = 4;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } stereo_t;

    // System clocks per audio frame for a given MCLK divider.
    function automatic int frame_clks(input int mclk_div);
        return FRAME_SLOTS * SLOT_MCLK * mclk_div;
    endfunction

endpackage

// File: rtl/i2s_shift.sv
// One I2S channel: holds the loaded word and shifts it out MSB first, one bit per slot.
// Latency: bit_nxt_o is combinational; the parent registers it on the slot strobe.
// Backpressure: none, driven purely by the frame timing strobes.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   load_i         capture din_i as the channel word (frame boundary)
//   din_i          sample word, two's complement
//   slot_stb_i     start of a bit slot belonging to this channel's half-frame
//   slot_first_i   qualifies slot_stb_i as slot 0 of the half-frame
//   bit_nxt_o      serial bit to present for the slot being started
module i2s_shift #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              slot_stb_i,
    input  logic              slot_first_i,
    output logic              bit_nxt_o
);

    logic [DATA_W-1:0] word_q, word_d;
    logic [31:0]       sr_q, sr_d;

    always_comb begin
        // The left channel's slot 0 coincides with the frame load, so the
        // shift register must see the word being loaded in the same cycle.
        word_d = load_i ? din_i : word_q;
        sr_d   = sr_q;
        if (slot_stb_i) begin
            if (slot_first_i) begin
                // Slot 0 carries the I2S one-slot delay bit; the word starts at slot 1.
                sr_d = {word_d, {(32-DATA_W){1'b0}}};
            end else begin
                sr_d = {sr_q[30:0], 1'b0};
            end
        end
    end

    assign bit_nxt_o = slot_first_i ? 1'b0 : sr_q[31];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            sr_q   <= '0;
        end else begin
            word_q <= word_d;
            sr_q   <= sr_d;
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC serializer: one stereo pair per frame in, MCLK/LRCK/SDATA out to the audio DAC.
// Latency: accept to first serial bit at most 2 frames + 1 slot; all outputs registered.
// Backpressure: single holding register; sample_ready drops when full and reopens on the frame load.
//
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   en                      run enable; low parks the frame counter at 0 and zeros the DAC pins
//   sample_l/_r, sample_valid, sample_ready   pair handshake from the sound block
//   frame_stb               pulse on the last clk of each frame (next-pair request)
//   underrun                pulse when a frame load finds the holding register empty
//   dac_mclk, dac_lrck, dac_sdata              DAC pins (256*fs, fs, serial data)
module i2s_dac_tx
    import tsxb_audio_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int MCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              frame_stb,
    output logic              underrun,
    output logic              dac_mclk,
    output logic              dac_lrck,
    output logic              dac_sdata
);

    localparam int              M         = $clog2(MCLK_DIV);
    localparam int              CW        = M + 8;
    localparam int              FRAME_CLK = frame_clks(MCLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(FRAME_CLK - 1);

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    logic [CW-1:0] cnt_q, cnt_d;
    pair_t         hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          ready_q, ready_d;
    logic          frame_stb_q, frame_stb_d;
    logic          underrun_q, underrun_d;
    logic          mclk_q, mclk_d;
    logic          lrck_q, lrck_d;
    logic          sdata_q, sdata_d;

    logic          load;
    logic          accept;
    logic          shift_load;
    logic          bclk_fall;
    logic          half_r;
    logic          slot_first;
    logic          frame_end_d;
    logic          bit_l, bit_r;

    assign load       = (cnt_q == CNT_MAX);
    assign accept     = sample_valid && ready_q;
    // An empty holding register at load leaves the shift words untouched,
    // so the previous pair is replayed.
    assign shift_load = load && hold_full_q;

    // Every output register is computed from cnt_d so that, once clocked,
    // all pins reflect the same cnt_q value with no relative skew.
    always_comb begin
        cnt_d       = en ? cnt_q + CW'(1) : '0;

        hold_d      = hold_q;
        if (accept) begin
            hold_d.l = sample_l;
            hold_d.r = sample_r;
        end
        // At load the old contents move to the shift words; a same-cycle
        // accept refills the register.
        hold_full_d = load ? accept : (hold_full_q || accept);

        bclk_fall   = (cnt_d[M+1:0] == '0);
        half_r      = cnt_d[M+7];
        slot_first  = (cnt_d[M+6:M+2] == '0);
        frame_end_d = (cnt_d == CNT_MAX);

        ready_d     = !hold_full_d || frame_end_d;
        frame_stb_d = frame_end_d;
        underrun_d  = frame_end_d && !hold_full_d;

        mclk_d      = en && cnt_d[M-1];
        lrck_d      = en && half_r;

        sdata_d     = sdata_q;
        if (!en) begin
            sdata_d = 1'b0;
        end else if (bclk_fall) begin
            sdata_d = half_r ? bit_r : bit_l;
        end
    end

    i2s_shift #(.DATA_W(DATA_W)) u_shift_l (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (shift_load),
        .din_i        (hold_q.l),
        .slot_stb_i   (bclk_fall && !half_r),
        .slot_first_i (slot_first),
        .bit_nxt_o    (bit_l)
    );

    i2s_shift #(.DATA_W(DATA_W)) u_shift_r (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (shift_load),
        .din_i        (hold_q.r),
        .slot_stb_i   (bclk_fall && half_r),
        .slot_first_i (slot_first),
        .bit_nxt_o    (bit_r)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            frame_stb_q <= 1'b0;
            underrun_q  <= 1'b0;
            mclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            frame_stb_q <= frame_stb_d;
            underrun_q  <= underrun_d;
            mclk_q      <= mclk_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
        end
    end

    assign sample_ready = ready_q;
    assign frame_stb    = frame_stb_q;
    assign underrun     = underrun_q;
    assign dac_mclk     = mclk_q;
    assign dac_lrck     = lrck_q;
    assign dac_sdata    = sdata_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
module tb_i2s_dac_tx;

    localparam int DATA_W   = 16;
    localparam int MCLK_DIV = 4;
    localparam int FRAME    = 256 * MCLK_DIV;
    localparam int SLOT     = 4 * MCLK_DIV;
    localparam int MAXK     = FRAME - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        frame_stb;
    logic        underrun;
    logic        dac_mclk;
    logic        dac_lrck;
    logic        dac_sdata;

    int checks = 0;
    int errors = 0;

    // Reference model: frame position, holding register, words being played.
    int          m_k;
    logic        m_full;
    logic        m_fresh;
    logic [15:0] m_l, m_r, m_hl, m_hr;

    i2s_dac_tx #(.DATA_W(DATA_W), .MCLK_DIV(MCLK_DIV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_stb    (frame_stb),
        .underrun     (underrun),
        .dac_mclk     (dac_mclk),
        .dac_lrck     (dac_lrck),
        .dac_sdata    (dac_sdata)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_ready();
        return !m_fresh && (!m_full || m_k == MAXK);
    endfunction

    function automatic logic exp_mclk(input int k);
        return ((k / (MCLK_DIV / 2)) % 2) == 1;
    endfunction

    function automatic logic exp_lrck(input int k);
        return k >= FRAME / 2;
    endfunction

    // I2S placement: slot 0 of each half is the delay bit, word MSB..LSB in slots 1..DATA_W.
    function automatic logic exp_sdata(input int k, input logic [15:0] l, input logic [15:0] r);
        int          slot;
        int          s;
        logic [15:0] w;
        slot = k / SLOT;
        s    = slot % 32;
        w    = (slot >= 32) ? r : l;
        if (s >= 1 && s <= DATA_W) return w[DATA_W - s];
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, step the reference model across the edge,
    // and return #1 after the edge with outputs settled.
    task automatic tick(input logic v, input logic [15:0] l, input logic [15:0] r, input logic e);
        logic acc;
        sample_valid = v;
        sample_l     = l;
        sample_r     = r;
        en           = e;
        acc          = v && exp_ready();
        @(posedge clk);
        if (m_k == MAXK) begin
            if (m_full) begin
                m_l = m_hl;
                m_r = m_hr;
            end
            m_full = acc;
        end else begin
            m_full = m_full || acc;
        end
        if (acc) begin
            m_hl = l;
            m_hr = r;
        end
        m_k     = e ? (m_k + 1) % FRAME : 0;
        m_fresh = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        en           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_k     = 0;
        m_full  = 1'b0;
        m_fresh = 1'b1;
        m_l = '0; m_r = '0; m_hl = '0; m_hr = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dac_mclk !== 1'b0)     begin errors++; $display("FAIL rst_mclk got %b exp 0", dac_mclk); end
        checks++; if (dac_lrck !== 1'b0)     begin errors++; $display("FAIL rst_lrck got %b exp 0", dac_lrck); end
        checks++; if (dac_sdata !== 1'b0)    begin errors++; $display("FAIL rst_sdata got %b exp 0", dac_sdata); end
        checks++; if (frame_stb !== 1'b0)    begin errors++; $display("FAIL rst_frame_stb got %b exp 0", frame_stb); end
        checks++; if (underrun !== 1'b0)     begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", sample_ready); end
        do_reset();
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_c0 got %b exp 0", sample_ready); end
        tick(1'b0, '0, '0, 1'b1);
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_c1 got %b exp 1", sample_ready); end
    endtask

    task automatic test_clocks();
        for (int i = 0; i < 2100; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            checks++; if (dac_mclk !== exp_mclk(m_k))       begin errors++; $display("FAIL clk_mclk k=%0d got %b exp %b", m_k, dac_mclk, exp_mclk(m_k)); end
            checks++; if (dac_lrck !== exp_lrck(m_k))       begin errors++; $display("FAIL clk_lrck k=%0d got %b exp %b", m_k, dac_lrck, exp_lrck(m_k)); end
            checks++; if (frame_stb !== (m_k == MAXK))      begin errors++; $display("FAIL clk_frame_stb k=%0d got %b exp %b", m_k, frame_stb, m_k == MAXK); end
            checks++; if (underrun !== (m_k == MAXK && !m_full)) begin errors++; $display("FAIL clk_underrun k=%0d got %b", m_k, underrun); end
            checks++; if (dac_sdata !== 1'b0)               begin errors++; $display("FAIL clk_sdata k=%0d got %b exp 0", m_k, dac_sdata); end
        end
    endtask

    task automatic test_single_pair();
        tick(1'b1, 16'h8001, 16'h7FFE, 1'b1);
        checks++; if (sample_ready !== exp_ready()) begin errors++; $display("FAIL single_ready got %b exp %b", sample_ready, exp_ready()); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            checks++;
            if (dac_sdata !== exp_sdata(m_k, m_l, m_r)) begin
                errors++; $display("FAIL single_sdata k=%0d got %b exp %b", m_k, dac_sdata, exp_sdata(m_k, m_l, m_r));
            end
        end
    endtask

    task automatic test_back_to_back();
        int rdy_cnt;
        while (m_k != 0) tick(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        rdy_cnt = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (sample_ready === 1'b1) rdy_cnt++;
            tick(1'b1, 16'($urandom), 16'($urandom), 1'b1);
            checks++; if (sample_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready k=%0d got %b exp %b", m_k, sample_ready, exp_ready()); end
            checks++; if (dac_sdata !== exp_sdata(m_k, m_l, m_r)) begin errors++; $display("FAIL b2b_sdata k=%0d got %b exp %b", m_k, dac_sdata, exp_sdata(m_k, m_l, m_r)); end
        end
        checks++; if (rdy_cnt != 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", rdy_cnt); end
    endtask

    task automatic test_underrun();
        int guard;
        guard = 0;
        while (!exp_ready() && guard < 2 * FRAME) begin tick(1'b0, '0, '0, 1'b1); guard++; end
        tick(1'b1, 16'h1234, 16'($urandom), 1'b1);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            checks++; if (underrun !== (m_k == MAXK && !m_full)) begin errors++; $display("FAIL urun_pulse k=%0d got %b", m_k, underrun); end
            checks++; if (sample_ready !== exp_ready()) begin errors++; $display("FAIL urun_ready k=%0d got %b exp %b", m_k, sample_ready, exp_ready()); end
            checks++; if (dac_sdata !== exp_sdata(m_k, m_l, m_r)) begin errors++; $display("FAIL urun_sdata k=%0d got %b exp %b", m_k, dac_sdata, exp_sdata(m_k, m_l, m_r)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), 1'b1);
            checks++; if (sample_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready k=%0d got %b exp %b", m_k, sample_ready, exp_ready()); end
            checks++; if (underrun !== (m_k == MAXK && !m_full)) begin errors++; $display("FAIL rnd_underrun k=%0d got %b", m_k, underrun); end
            checks++; if (dac_sdata !== exp_sdata(m_k, m_l, m_r)) begin errors++; $display("FAIL rnd_sdata k=%0d got %b exp %b", m_k, dac_sdata, exp_sdata(m_k, m_l, m_r)); end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] pr;
        int          guard;
        pr = 16'($urandom) | 16'h8000;
        guard = 0;
        while (!exp_ready() && guard < 2 * FRAME) begin tick(1'b0, '0, '0, 1'b1); guard++; end
        tick(1'b1, 16'($urandom), pr, 1'b1);
        guard = 0;
        while (!(m_k == 530 && m_r == pr) && guard < 3 * FRAME) begin tick(1'b0, '0, '0, 1'b1); guard++; end
        checks++; if (guard >= 3 * FRAME) begin errors++; $display("FAIL mrst_reach got guard %0d exp < %0d", guard, 3 * FRAME); end
        checks++; if (dac_mclk !== exp_mclk(m_k))  begin errors++; $display("FAIL mrst_pre_mclk got %b exp %b", dac_mclk, exp_mclk(m_k)); end
        checks++; if (dac_lrck !== exp_lrck(m_k))  begin errors++; $display("FAIL mrst_pre_lrck got %b exp %b", dac_lrck, exp_lrck(m_k)); end
        checks++; if (dac_sdata !== exp_sdata(m_k, m_l, m_r)) begin errors++; $display("FAIL mrst_pre_sdata got %b exp %b", dac_sdata, exp_sdata(m_k, m_l, m_r)); end
        reset_n = 1'b0;
        #1;
        checks++; if (dac_mclk !== 1'b0)  begin errors++; $display("FAIL mrst_mclk got %b exp 0", dac_mclk); end
        checks++; if (dac_lrck !== 1'b0)  begin errors++; $display("FAIL mrst_lrck got %b exp 0", dac_lrck); end
        checks++; if (dac_sdata !== 1'b0) begin errors++; $display("FAIL mrst_sdata got %b exp 0", dac_sdata); end
        do_reset();
        for (int i = 0; i < FRAME + 64; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            checks++; if (dac_lrck !== exp_lrck(m_k)) begin errors++; $display("FAIL mrst_post_lrck k=%0d got %b exp %b", m_k, dac_lrck, exp_lrck(m_k)); end
            checks++; if (dac_sdata !== 1'b0)         begin errors++; $display("FAIL mrst_post_sdata k=%0d got %b exp 0", m_k, dac_sdata); end
        end
    endtask

    task automatic test_mid_disable();
        logic [15:0] pl, pr;
        int          guard;
        pl = 16'($urandom);
        pr = 16'($urandom);
        guard = 0;
        while (!exp_ready() && guard < 2 * FRAME) begin tick(1'b0, '0, '0, 1'b1); guard++; end
        tick(1'b1, pl, pr, 1'b1);
        guard = 0;
        while (!(m_k == 700 && m_l == pl) && guard < 3 * FRAME) begin tick(1'b0, '0, '0, 1'b1); guard++; end
        checks++; if (guard >= 3 * FRAME) begin errors++; $display("FAIL mdis_reach got guard %0d exp < %0d", guard, 3 * FRAME); end
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, 16'($urandom), 16'($urandom), 1'b0);
            checks++; if (dac_mclk !== 1'b0)  begin errors++; $display("FAIL mdis_mclk i=%0d got %b exp 0", i, dac_mclk); end
            checks++; if (dac_lrck !== 1'b0)  begin errors++; $display("FAIL mdis_lrck i=%0d got %b exp 0", i, dac_lrck); end
            checks++; if (dac_sdata !== 1'b0) begin errors++; $display("FAIL mdis_sdata i=%0d got %b exp 0", i, dac_sdata); end
            checks++; if (frame_stb !== 1'b0) begin errors++; $display("FAIL mdis_frame_stb i=%0d got %b exp 0", i, frame_stb); end
            checks++; if (sample_ready !== exp_ready()) begin errors++; $display("FAIL mdis_ready i=%0d got %b exp %b", i, sample_ready, exp_ready()); end
        end
        for (int i = 0; i < FRAME + 100; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            checks++; if (dac_lrck !== exp_lrck(m_k)) begin errors++; $display("FAIL mdis_post_lrck k=%0d got %b exp %b", m_k, dac_lrck, exp_lrck(m_k)); end
            checks++; if (dac_mclk !== exp_mclk(m_k)) begin errors++; $display("FAIL mdis_post_mclk k=%0d got %b exp %b", m_k, dac_mclk, exp_mclk(m_k)); end
            checks++; if (dac_sdata !== exp_sdata(m_k, m_l, m_r)) begin errors++; $display("FAIL mdis_post_sdata k=%0d got %b exp %b", m_k, dac_sdata, exp_sdata(m_k, m_l, m_r)); end
        end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_single_pair();
        test_back_to_back();
        test_underrun();
        test_random();
        test_mid_reset();
        test_mid_disable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
